// File: rtl/smem_output_collector.sv
// Collects result beats from a streaming source into a show-ahead FIFO and hands them to the host.
// Accept-to-host_valid latency is one cycle; a registered stall freezes the source one entry before the FIFO is full.
module smem_output_collector #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 output_request,
  output logic                 output_permit,
  input  logic [511:0]         output_data,
  input  logic                 output_valid,
  input  logic                 output_finish,
  output logic                 stall,
  output logic [511:0]         host_data,
  output logic                 host_valid,
  input  logic                 host_ready,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic                 batch_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] STALL_LVL = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT_REQ, GRANT, DRAIN} state_t;

  state_t               state_q;
  logic                 permit_q;
  logic                 stall_q;
  logic                 done_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          occ_q;
  logic [AW:0]          occ_d;
  logic [511:0]         mem_q [FIFO_DEPTH];
  logic                 push;
  logic                 pop;

  // stall_q is the value the source saw before this edge, so a frozen beat is taken exactly once
  assign push = (state_q == GRANT) && output_valid && !stall_q;
  assign pop  = (occ_q != '0) && host_ready;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      permit_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            state_q <= WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (output_request) begin
            permit_q <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (output_finish && !stall_q) begin
            permit_q <= 1'b0;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (push && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q   <= occ_d;
      stall_q <= (occ_d >= STALL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= output_data;
  end

  assign output_permit = permit_q;
  assign stall         = stall_q;
  assign host_valid    = (occ_q != '0);
  assign host_data     = mem_q[rd_ptr_q];
  assign beat_count    = cnt_q;
  assign batch_done    = done_q;

endmodule

// File: tb/tb_smem_output_collector.sv
// Scoreboard bench: source model pushes accepted beats, host-side monitor pops and compares.
module tb_smem_output_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         output_request;
  logic         output_permit;
  logic [511:0] output_data;
  logic         output_valid;
  logic         output_finish;
  logic         stall;
  logic [511:0] host_data;
  logic         host_valid;
  logic         host_ready;
  logic [15:0]  beat_count;
  logic         batch_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [511:0] sb[$];

  smem_output_collector #(.FIFO_DEPTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .output_request(output_request),
    .output_permit(output_permit), .output_data(output_data), .output_valid(output_valid),
    .output_finish(output_finish), .stall(stall), .host_data(host_data),
    .host_valid(host_valid), .host_ready(host_ready), .beat_count(beat_count),
    .batch_done(batch_done)
  );

  always #5 clk = ~clk;

  // host-side monitor: every pop is compared against the scoreboard head
  always @(negedge clk) begin
    if (!reset && host_valid && host_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h, expected no beat", host_data[31:0]);
      end else begin
        if (host_data !== sb[0]) begin
          errors++;
          $display("FAIL pop_data: got %0h, expected %0h", host_data[31:0], sb[0][31:0]);
        end
        void'(sb.pop_front());
      end
    end
    if (!reset && batch_done) begin
      done_cnt++;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL done_early: %0d beats undelivered, expected 0", sb.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_batch();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (beat_count !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clear: got %0d, expected 0", beat_count);
    end
    output_request = 1'b1;
    @(negedge clk);
    checks++;
    if (output_permit !== 1'b0) begin
      errors++;
      $display("FAIL permit_early: got %b, expected 0", output_permit);
    end
    tick();
    checks++;
    if (output_permit !== 1'b1) begin
      errors++;
      $display("FAIL permit_rise: got %b, expected 1", output_permit);
    end
    output_request = 1'b0;
  endtask

  // presents beats base..base+n-1, holding each while stall is high
  task automatic run_source(input int n, input int base, input bit gaps,
                            input bit fin_last, input bit send_fin);
    bit acc;
    int budget;
    for (int i = 0; i < n; i++) begin
      output_valid  = 1'b1;
      output_data   = 512'(base + i);
      output_finish = fin_last && (i == n - 1);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 300) begin
        @(negedge clk);
        acc = !stall;
        if (acc) sb.push_back(512'(base + i));
        tick();
        budget++;
      end
      if (!acc) begin
        errors++;
        $display("FAIL src_timeout: beat %0d not accepted, stall=%b", i, stall);
        output_valid = 1'b0;
        output_finish = 1'b0;
        return;
      end
      if (fin_last && i == n - 1) begin
        checks++;
        if (output_permit !== 1'b0) begin
          errors++;
          $display("FAIL permit_drop_last: got %b, expected 0", output_permit);
        end
      end
      if (gaps) begin
        output_valid  = 1'b0;
        output_finish = 1'b0;
        tick();
      end
    end
    output_valid = 1'b0;
    output_finish = 1'b0;
    if (send_fin && !fin_last) begin
      output_finish = 1'b1;
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 300) begin
        @(negedge clk);
        acc = !stall;
        tick();
        budget++;
      end
      output_finish = 1'b0;
      checks++;
      if (output_permit !== 1'b0) begin
        errors++;
        $display("FAIL permit_drop: got %b, expected 0", output_permit);
      end
    end
  endtask

  task automatic wait_done(input int d0, input int exp_cnt);
    int budget = 0;
    while (done_cnt == d0 && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d, expected 1", done_cnt - d0);
    end
    checks++;
    if (beat_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL beat_count: got %0d, expected %0d", beat_count, exp_cnt);
    end
    checks++;
    if (sb.size() != 0 || host_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: left %0d host_valid=%b, expected 0 and 0", sb.size(), host_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; output_request = 1'b0; output_valid = 1'b0;
    output_finish = 1'b0; output_data = '0; host_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({output_permit, stall, host_valid, batch_done} !== 4'b0 || beat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: permit/stall/hv/done=%b%b%b%b cnt=%0d, expected 0000 0",
               output_permit, stall, host_valid, batch_done, beat_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idle_request();
    output_request = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (output_permit !== 1'b0) begin
        errors++;
        $display("FAIL idle_request: permit=%b, expected 0", output_permit);
      end
    end
    tick();
    output_request = 1'b0;
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    host_ready = 1'b1;
    open_batch();
    run_source(5, 1, 1'b0, 1'b0, 1'b1);
    wait_done(d0, 5);
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    int budget = 0;
    host_ready = 1'b0;
    open_batch();
    fork
      run_source(40, 'h100, 1'b0, 1'b0, 1'b1);
      begin
        while (stall !== 1'b1 && budget < 100) begin
          @(negedge clk);
          checks++;
          if (stall !== 1'b1 && beat_count >= 16'd15) begin
            errors++;
            $display("FAIL stall_late: cnt=%0d, expected stall by 15", beat_count);
          end
          budget++;
        end
        checks++;
        if (beat_count !== 16'd15) begin
          errors++;
          $display("FAIL stall_level: cnt=%0d at stall, expected 15", beat_count);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (beat_count !== 16'd15 || stall !== 1'b1) begin
          errors++;
          $display("FAIL frozen: cnt=%0d stall=%b, expected 15 1", beat_count, stall);
        end
        tick();
        host_ready = 1'b1;
      end
    join
    wait_done(d0, 40);
  endtask

  task automatic test_gaps();
    int d0 = done_cnt;
    host_ready = 1'b1;
    open_batch();
    run_source(2, 'h200, 1'b1, 1'b0, 1'b1);
    wait_done(d0, 2);
  endtask

  task automatic test_finish_with_last();
    int d0 = done_cnt;
    host_ready = 1'b1;
    open_batch();
    run_source(3, 'h300, 1'b0, 1'b1, 1'b1);
    wait_done(d0, 3);
  endtask

  task automatic test_reset_mid();
    int d0;
    host_ready = 1'b0;
    open_batch();
    run_source(7, 'h400, 1'b0, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (host_valid !== 1'b0 || output_permit !== 1'b0 || beat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: hv=%b permit=%b cnt=%0d, expected 0 0 0",
               host_valid, output_permit, beat_count);
    end
    sb.delete();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    output_request = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (output_permit !== 1'b0) begin
        errors++;
        $display("FAIL start_in_reset: permit=%b, expected 0", output_permit);
      end
    end
    tick();
    output_request = 1'b0;
    d0 = done_cnt;
    host_ready = 1'b1;
    open_batch();
    run_source(4, 'h500, 1'b0, 1'b0, 1'b1);
    wait_done(d0, 4);
  endtask

  initial begin
    test_reset();
    test_idle_request();
    test_basic();
    test_backpressure();
    test_gaps();
    test_finish_with_last();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/smem_output_collector.md
SMEM_OUTPUT_COLLECTOR -- requirements
Module: smem_output_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning beat buffer entries (power of two, >=8).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning width of the beat counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms the collector for a new batch.
REQ-006 SHALL have port output_request  input  1  source has all results ready.
REQ-007 SHALL have port output_permit  output  1  grant that lets the source stream.
REQ-008 SHALL have port output_data  input  512  result beat.
REQ-009 SHALL have port output_valid  input  1  output_data is a valid beat.
REQ-010 SHALL have port output_finish  input  1  source has emitted its last beat.
REQ-011 SHALL have port stall  output  1  backpressure to the source pipeline; the source freezes its registers while it is high.
REQ-012 SHALL have port host_data  output  512  FIFO head beat.
REQ-013 SHALL have port host_valid  output  1  host_data is valid.
REQ-014 SHALL have port host_ready  input  1  host consumes the head beat.
REQ-015 SHALL have port beat_count  output  CNT_WIDTH  beats accepted this batch.
REQ-016 SHALL have port batch_done  output  1  one-cycle pulse when the batch has been fully delivered.

Function
REQ-017 SHALL implement the FSM IDLE -> WAIT_REQ -> GRANT -> DRAIN -> IDLE.
REQ-018 IDLE: start=1 SHALL clear beat_count and move to WAIT_REQ; all other inputs are ignored.
REQ-019 WAIT_REQ: output_request=1 SHALL move to GRANT and set output_permit=1 on the same edge.
REQ-020 GRANT: output_permit SHALL be held at 1 until output_finish=1 is sampled with stall=0; on that edge output_permit SHALL go to 0 and the FSM SHALL go to DRAIN.
REQ-021 DRAIN: when the FIFO is empty, the FSM SHALL pulse batch_done for one cycle and return to IDLE.
REQ-022 Beat acceptance SHALL occur on any edge in GRANT with output_valid=1 and registered stall=0 (stall value before the edge). The beat SHALL be pushed into the FIFO and beat_count SHALL be incremented. A frozen beat held while stall=1 SHALL be accepted exactly once, after stall releases.
REQ-023 output_valid SHALL be ignored outside GRANT; gaps (output_valid=0 between groups) SHALL be tolerated without side effect.
REQ-024 stall SHALL be registered: stall <= (next FIFO occupancy >= FIFO_DEPTH-1). The FIFO therefore never overflows, and no beat is lost or duplicated.
REQ-025 The FIFO SHALL be show-ahead: host_valid = (occupancy != 0) and host_data = head entry. A pop SHALL occur on each edge with host_valid && host_ready.
REQ-026 A simultaneous push and pop SHALL leave occupancy unchanged. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 Latency from accepted beat to host_valid (empty FIFO) SHALL be 1 cycle; data order SHALL be preserved.
REQ-028 beat_count SHALL saturate at all ones and never wrap.
REQ-029 A start pulse outside IDLE SHALL be ignored.
REQ-030 output_finish arriving on the same edge as a final accepted beat SHALL both push the beat and enter DRAIN.

Reset
REQ-031 On reset, asynchronously: FSM=IDLE, output_permit=0, stall=0, FIFO pointers and occupancy=0, host_valid=0, beat_count=0, batch_done=0; host_data is don't-care.
REQ-032 Reset asserted mid-batch SHALL discard FIFO contents; after release the block waits for a new start pulse.

Verification
REQ-033 Scenario: start, output_request=1, 5 beats (values 1..5) then finish, host_ready=1 -> permit rises 1 cycle after request; host sees 1..5 in order; beat_count=5; single batch_done pulse after the last pop.
REQ-034 Scenario: host_ready=0, source streams 40 beats -> stall rises once occupancy reaches 15; source frozen; no overflow. Then host_ready=1 -> all 40 beats delivered exactly once, in order, no duplicates.
REQ-035 Scenario: valid gaps (beat, idle, beat, idle) -> only the 2 valid beats pushed; beat_count=2.
REQ-036 Scenario: output_finish on the same edge as beat 3 -> 3 beats delivered; permit drops on that edge; batch_done after drain.
REQ-037 Scenario: reset asserted with 7 beats buffered -> host_valid=0 and permit=0 immediately; start ignored until reset is released; a new batch runs cleanly.
REQ-038 Scenario: output_request=1 while in IDLE without start -> output_permit stays 0.
